// File: rtl/ad9226_capture_ctrl.sv
// AD9226 capture controller: ADC clock divider, sample capture FSM and stream output.
// Define AD9226_CAPTURE_LEVEL_TRIG_EN to compile in the level-crossing trigger.
module ad9226_capture_ctrl #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              master_clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ad9226_data,
    input  logic              ad9226_otr,
    output logic              ad9226_clk,
    input  logic [7:0]        cfg_clk_div,
    input  logic [CNT_W-1:0]  cfg_num_samples,
`ifdef AD9226_CAPTURE_LEVEL_TRIG_EN
    input  logic [DATA_W-1:0] cfg_trig_level,
    input  logic              cfg_trig_rising,
`endif
    input  logic              start,
    input  logic              abort,
    output logic [DATA_W-1:0] m_data,
    output logic              m_otr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  otr_count
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StWaitTrig, StCapture, StDone} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   din_q;
    logic                otr_q;
    logic [7:0]          div_cnt_q, div_cnt_d;
    logic                adc_clk_q, adc_clk_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_otr_q, m_otr_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [CNT_W-1:0]    otr_count_q, otr_count_d;
    logic                div_wrap, strobe, trig_hit, take;

    // Divider always runs; >= keeps it from sticking if cfg_clk_div shrinks mid-count.
    always_comb begin
        div_wrap  = div_cnt_q >= cfg_clk_div;
        div_cnt_d = div_wrap ? 8'd0 : div_cnt_q + 8'd1;
        adc_clk_d = div_wrap ? ~adc_clk_q : adc_clk_q;
        strobe    = div_wrap && adc_clk_q;
    end

`ifdef AD9226_CAPTURE_LEVEL_TRIG_EN
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              have_prev_q, have_prev_d;
    logic              rise_hit, fall_hit;

    always_comb begin
        rise_hit    = (prev_q < cfg_trig_level) && (cfg_trig_level <= din_q);
        fall_hit    = (prev_q >= cfg_trig_level) && (cfg_trig_level > din_q);
        trig_hit    = have_prev_q && (cfg_trig_rising ? rise_hit : fall_hit);
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        if (state_q == StIdle && start && !abort) begin
            have_prev_d = 1'b0;
        end else if (state_q == StWaitTrig && strobe) begin
            prev_d      = din_q;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            prev_q      <= '0;
            have_prev_q <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
        end
    end
`else
    assign trig_hit = 1'b0;
`endif

    assign take = strobe && ((state_q == StCapture) || (state_q == StWaitTrig && trig_hit));

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_otr_d     = m_otr_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        otr_count_d = otr_count_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (take) begin
            remaining_d = remaining_q - CntOne;
            if (otr_q && otr_count_q != '1) begin
                otr_count_d = otr_count_q + CntOne;
            end
            if (m_valid_q && !m_ready) begin
                overflow_d = 1'b1;
            end else begin
                m_data_d  = din_q;
                m_otr_d   = otr_q;
                m_valid_d = 1'b1;
                m_last_d  = (remaining_q == CntOne);
            end
            state_d = (remaining_q == CntOne) ? StDone : StCapture;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    overflow_d  = 1'b0;
                    otr_count_d = '0;
                    remaining_d = cfg_num_samples;
                    state_d     = (cfg_num_samples == '0) ? StDone : StWaitTrig;
                end
            end
            StWaitTrig: begin
`ifndef AD9226_CAPTURE_LEVEL_TRIG_EN
                state_d = StCapture;
`endif
            end
            StCapture: begin
            end
            StDone: begin
                // Finish as soon as the last pending word is gone, including this cycle's handshake.
                if (!m_valid_d) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d   = StIdle;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            din_q       <= '0;
            otr_q       <= 1'b0;
            div_cnt_q   <= 8'd0;
            adc_clk_q   <= 1'b0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_otr_q     <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            otr_count_q <= '0;
        end else begin
            state_q     <= state_d;
            din_q       <= ad9226_data;
            otr_q       <= ad9226_otr;
            div_cnt_q   <= div_cnt_d;
            adc_clk_q   <= adc_clk_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_otr_q     <= m_otr_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            otr_count_q <= otr_count_d;
        end
    end

    assign ad9226_clk = adc_clk_q;
    assign m_data     = m_data_q;
    assign m_otr      = m_otr_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign otr_count  = otr_count_q;

endmodule

// File: tb/tb_ad9226_capture_ctrl.sv
// Directed self-checking bench for ad9226_capture_ctrl with a ramp ADC model.
module tb_ad9226_capture_ctrl;

    logic        master_clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] ad9226_data = '0;
    logic        ad9226_otr = 1'b0;
    logic        ad9226_clk;
    logic [7:0]  cfg_clk_div = 8'd3;
    logic [15:0] cfg_num_samples = '0;
`ifdef AD9226_CAPTURE_LEVEL_TRIG_EN
    logic [11:0] cfg_trig_level = 12'h800;
    logic        cfg_trig_rising = 1'b1;
`endif
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] m_data;
    logic        m_otr;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] otr_count;

    ad9226_capture_ctrl dut (
        .master_clock    (master_clock),
        .reset           (reset),
        .ad9226_data     (ad9226_data),
        .ad9226_otr      (ad9226_otr),
        .ad9226_clk      (ad9226_clk),
        .cfg_clk_div     (cfg_clk_div),
        .cfg_num_samples (cfg_num_samples),
`ifdef AD9226_CAPTURE_LEVEL_TRIG_EN
        .cfg_trig_level  (cfg_trig_level),
        .cfg_trig_rising (cfg_trig_rising),
`endif
        .start           (start),
        .abort           (abort),
        .m_data          (m_data),
        .m_otr           (m_otr),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .otr_count       (otr_count)
    );

    always #5 master_clock = ~master_clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // ADC model: each rising ad9226_clk presents base + k*step; the first otr_n samples flag OTR.
    int ramp_base = 0, ramp_step = 0, rise_ref = 0, otr_n = 0;
    int rise_cnt  = 0;

    // Monitor results.
    logic [13:0] words[$];
    int valid_cycles = 0, done_cnt = 0, hs_cyc = 0, done_cyc = 0;
    int fall_cnt = 0, fall_cyc = 0, fall_gap = 0;
    logic adc_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    initial forever begin
        @(posedge master_clock);
        cyc++;
    end

    initial forever begin
        @(posedge ad9226_clk);
        rise_cnt++;
        ad9226_data = 12'(ramp_base + (rise_cnt - rise_ref) * ramp_step);
        ad9226_otr  = ((rise_cnt - rise_ref) <= otr_n);
    end

    initial forever begin
        @(negedge master_clock);
        if (!reset) begin
            if (adc_prev && !ad9226_clk) begin
                fall_gap = cyc - fall_cyc;
                fall_cyc = cyc;
                fall_cnt++;
            end
            adc_prev = ad9226_clk;
            if (m_valid) valid_cycles++;
            if (m_valid && m_ready) begin
                words.push_back({m_last, m_otr, m_data});
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge master_clock);
        #1;
    endtask

    // Align to just after a strobe, program the ramp, then pulse start.
    task automatic arm(input int base, input int step, input int otr_cnt);
        int f0 = fall_cnt;
        bit seen = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick(1);
            if (fall_cnt != f0) seen = 1;
        end
        if (!seen) check("arm_align_timeout", 0, 1);
        ramp_base = base;
        ramp_step = step;
        otr_n     = otr_cnt;
        rise_ref  = rise_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (done_cnt != d0) seen = 1;
        end
        check(tag, 32'(seen), 1);
    endtask

    int base_idx, d0, v0;

    initial begin
        // Reset state.
        tick(3);
        check("rst_adc_clk", 32'(ad9226_clk), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_otr_count", 32'(otr_count), 0);
        check("rst_m_data_last", {m_last, m_otr, m_data}, 0);
        @(negedge master_clock);
        reset = 1'b0;

        // Divider period with cfg_clk_div=3, strobing while idle.
        begin
            int f0 = fall_cnt;
            for (int i = 0; i < 64 && fall_cnt < f0 + 3; i++) tick(1);
            check("strobe_period", 32'(fall_gap), 8);
            check("idle_no_valid", 32'(valid_cycles), 0);
        end

        // start together with abort is ignored.
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 0);

`ifndef AD9226_CAPTURE_LEVEL_TRIG_EN
        // Four samples, ready held high; a stray start mid-capture is ignored.
        cfg_num_samples = 16'd4;
        m_ready = 1'b1;
        base_idx = words.size();
        d0 = done_cnt;
        arm(32'h100, 32'h10, 0);
        tick(12);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("norm_done", 100);
        check("norm_count", 32'(words.size() - base_idx), 4);
        if (words.size() >= base_idx + 4) begin
            check("norm_w0", 32'(words[base_idx]),     32'h0110);
            check("norm_w1", 32'(words[base_idx + 1]), 32'h0120);
            check("norm_w2", 32'(words[base_idx + 2]), 32'h0130);
            check("norm_w3", 32'(words[base_idx + 3]), 32'h2140);
        end
        check("norm_done_lat", 32'(done_cyc - hs_cyc), 1);
        check("norm_done_cnt", 32'(done_cnt - d0), 1);
        check("norm_overflow", 32'(overflow), 0);
        check("norm_busy", 32'(busy), 0);

        // Three samples with ready low: only the first is kept.
        cfg_num_samples = 16'd3;
        m_ready = 1'b0;
        base_idx = words.size();
        d0 = done_cnt;
        arm(32'h200, 32'h10, 0);
        tick(40);
        check("ovf_pending", {m_last, m_valid, m_data}, 32'h1210);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_no_done_yet", 32'(done_cnt - d0), 0);
        m_ready = 1'b1;
        wait_done("ovf_done", 20);
        tick(30);
        check("ovf_words", 32'(words.size() - base_idx), 1);
        check("ovf_valid_low", 32'(m_valid), 0);

        // Abort after two of ten samples.
        cfg_num_samples = 16'd10;
        base_idx = words.size();
        d0 = done_cnt;
        arm(32'h300, 32'h10, 0);
        for (int i = 0; i < 100 && words.size() < base_idx + 2; i++) tick(1);
        check("abort_two_words", 32'(words.size() - base_idx), 2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(m_valid), 0);
        tick(40);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_no_more", 32'(words.size() - base_idx), 2);

        cfg_num_samples = 16'd2;
        base_idx = words.size();
        arm(32'h400, 32'h10, 0);
        wait_done("post_abort_done", 60);
        check("post_abort_count", 32'(words.size() - base_idx), 2);
        if (words.size() >= base_idx + 2) begin
            check("post_abort_w0", 32'(words[base_idx]),     32'h0410);
            check("post_abort_w1", 32'(words[base_idx + 1]), 32'h2420);
        end

        // OTR on the first five of eight samples.
        cfg_num_samples = 16'd8;
        base_idx = words.size();
        arm(32'h500, 32'h10, 5);
        wait_done("otr_done", 120);
        check("otr_count", 32'(otr_count), 5);
        if (words.size() >= base_idx + 8) begin
            check("otr_w0", 32'(words[base_idx]),     32'h1510);
            check("otr_w5", 32'(words[base_idx + 5]), 32'h0560);
        end

        // Zero-length capture.
        cfg_num_samples = 16'd0;
        v0 = valid_cycles;
        arm(32'h600, 32'h10, 0);
        wait_done("zero_done", 10);
        check("zero_no_valid", 32'(valid_cycles - v0), 0);
        check("zero_otr_cleared", 32'(otr_count), 0);
`else
        // Rising trigger at 0x800 on a ramp 0x7F0, 0x7F8, 0x800, ...
        cfg_num_samples = 16'd2;
        cfg_trig_level  = 12'h800;
        cfg_trig_rising = 1'b1;
        m_ready = 1'b1;
        base_idx = words.size();
        arm(32'h7E8, 32'h8, 0);
        wait_done("trig_done", 100);
        check("trig_count", 32'(words.size() - base_idx), 2);
        if (words.size() >= base_idx + 2) begin
            check("trig_w0", 32'(words[base_idx]),     32'h0800);
            check("trig_w1", 32'(words[base_idx + 1]), 32'h2808);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad9226_capture_ctrl.md
AD9226_CAPTURE_CTRL -- requirements
Module: ad9226_capture_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving the ADC sample width.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the sample counter and the OTR counter.
REQ-003 master_clock  in  1  sole clock; all logic rises on it.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 ad9226_data  in  DATA_W  raw ADC data bus.
REQ-006 ad9226_otr  in  1  ADC out-of-range flag.
REQ-007 ad9226_clk  out  1  generated ADC sample clock.
REQ-008 cfg_clk_div  in  8  half-period of ad9226_clk minus 1, in master_clock cycles.
REQ-009 cfg_num_samples  in  CNT_W  samples per capture; sampled at start.
REQ-010 start  in  1  single-cycle capture request.
REQ-011 abort  in  1  single-cycle capture cancel.
REQ-012 m_data  out  DATA_W  captured sample.
REQ-013 m_otr  out  1  OTR flag of the sample in m_data.
REQ-014 m_valid  out  1  m_data holds a sample.
REQ-015 m_ready  in  1  downstream accepts the sample.
REQ-016 m_last  out  1  marks the final sample of a capture.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 overflow  out  1  sticky flag set when a sample is dropped.
REQ-020 otr_count  out  CNT_W  saturating count of OTR samples in the current capture.

Function
REQ-021 ad9226_data and ad9226_otr SHALL be registered on every cycle (din_q, otr_q), and all capture logic SHALL use these registered copies.
REQ-022 The divider counter SHALL run in every state: when count >= cfg_clk_div it toggles ad9226_clk and clears to 0, otherwise it increments; clock period is 2*(cfg_clk_div+1) cycles.
REQ-023 The strobe SHALL be the cycle in which ad9226_clk toggles from 1 to 0.
REQ-024 The FSM SHALL have states IDLE, WAIT_TRIG, CAPTURE and DONE.
REQ-025 In IDLE, start SHALL clear overflow and otr_count, latch cfg_num_samples into the remaining-sample counter, and enter WAIT_TRIG (see Configuration).
REQ-026 If the latched count is 0, start SHALL go straight to DONE and produce no samples.
REQ-027 In CAPTURE, each strobe SHALL load din_q/otr_q into m_data/m_otr and set m_valid on the next cycle; m_last SHALL be 1 when that sample is the final one.
REQ-028 The output handshake SHALL complete on m_valid && m_ready, which clears m_valid unless a new sample loads in the same cycle.
REQ-029 A strobe while m_valid && !m_ready SHALL drop the new sample, set overflow, and still decrement the counter.
REQ-030 If the dropped sample is the final one, the pending word keeps its own m_last value.
REQ-031 A strobe in CAPTURE with otr_q=1 SHALL increment otr_count, which saturates at all-ones.
REQ-032 After the final strobe the FSM SHALL enter DONE, wait until m_valid==0, then pulse done for one cycle and return to IDLE.
REQ-033 abort in any non-IDLE state SHALL return the FSM to IDLE on the next cycle, clear m_valid and m_last, and produce no done pulse; overflow and otr_count SHALL hold their values.
REQ-034 If start and abort are asserted together, abort SHALL win; start while busy SHALL be ignored.
REQ-035 A change to cfg_clk_div mid-count SHALL take effect without a stuck clock, because the divider compares with >=.

Reset
REQ-036 reset SHALL asynchronously force: FSM=IDLE, divider count=0, ad9226_clk=0, m_data=0, m_otr=0, m_valid=0, m_last=0, busy=0, done=0, overflow=0, otr_count=0, din_q=0, otr_q=0.
REQ-037 Reset asserted mid-capture SHALL discard the capture with no done pulse.

Configuration
REQ-038 The macro AD9226_CAPTURE_LEVEL_TRIG_EN SHALL compile the level trigger in or out.
REQ-039 With AD9226_CAPTURE_LEVEL_TRIG_EN defined, the block SHALL add inputs cfg_trig_level (DATA_W) and cfg_trig_rising (1).
REQ-040 With the macro defined, WAIT_TRIG SHALL compare consecutive strobe samples: rising means previous < level <= current; falling means previous >= level > current.
REQ-041 With the macro defined, the crossing sample SHALL be the first captured sample.
REQ-042 Without the macro, WAIT_TRIG SHALL last exactly one cycle before CAPTURE, and capture SHALL begin at the next strobe.

Verification
REQ-043 cfg_clk_div=3: ad9226_clk period is 8 cycles; strobe occurs every 8 cycles, also while IDLE.
REQ-044 cfg_num_samples=4, m_ready=1, ramp data: four words equal to din_q at each strobe, m_last on the 4th word, done 1 cycle after the 4th handshake, overflow=0.
REQ-045 cfg_num_samples=3, m_ready=0 throughout, then 1: only the first word is delivered, overflow=1, done still pulses, and no further m_valid occurs.
REQ-046 abort asserted after 2 of 10 samples: busy=0 and m_valid=0 the next cycle, no done pulse, and a following start runs normally.
REQ-047 otr held at 1 for 5 of 8 samples: otr_count=5; cfg_num_samples=0: done pulses with no m_valid.
REQ-048 With the macro defined, rising trigger, level 0x800, ramp 0x7F0 to 0x810 in steps of 8: the first captured word is 0x800.
